mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-port synchronous-write memory between the instruction-fetch unit (read only) and the data unit (load/store). Fixed data-port priority with a starvation guard for fetch. Registers all memory-side signals and returns read data with a one-cycle acknowledge pulse. Sits between the CPU core and the memory block.

Parameters:
ADDR_WIDTH, 8, memory address width; drives memory ADDR parameter
DATA_WIDTH, 16, data word width
MAX_BURST, 4, max consecutive data grants while fetch is waiting (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_WIDTH  fetch address
if_ack  out  1  one-cycle pulse; if_rdata valid same cycle
if_rdata  out  DATA_WIDTH  fetched word, registered
dm_req  in  1  data request; held with dm_we/addr/wdata until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_ack  out  1  one-cycle pulse; dm_rdata valid same cycle (loads)
dm_rdata  out  DATA_WIDTH  loaded word, registered
mem_address  out  ADDR_WIDTH  to memory address
mem_write_data  out  DATA_WIDTH  to memory write_data
mem_write_enable  out  1  to memory write_enable
mem_read_data  in  DATA_WIDTH  from memory read_data (combinational from address)
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset: state IDLE; all outputs 0; burst counter 0; owner = none. Synchronous only.
- States: IDLE -> ACCESS -> RESP -> IDLE. One access per 3 cycles.
- IDLE: if any req, choose winner, latch its address/we/wdata into mem_* regs, record owner, go ACCESS. No req: stay, mem_write_enable 0.
- Selection: dm wins if dm_req and (not if_req or burst_cnt < MAX_BURST); else if wins if if_req.
- burst_cnt: +1 when dm granted while if_req high; cleared when if granted or when dm granted with if_req low. Saturates at MAX_BURST.
- ACCESS: mem_write_enable = 1 only for a dm store (exactly this one cycle). At end of cycle, mem_read_data captured into owner's rdata reg (loads/fetches); go RESP.
- RESP: owner's ack = 1 for exactly one cycle; mem_write_enable 0; requests ignored; go IDLE. Non-owner rdata unchanged.
- Latency: req sampled in IDLE at cycle N -> ack at cycle N+2.
- Requester may keep req high after ack for a back-to-back request; it is resampled in next IDLE.
- Both acks never high together. rdata regs hold value until next own read completes; a store does not modify dm_rdata.
- Simultaneous if_req and dm_req with burst_cnt == MAX_BURST: if wins, counter clears.
- Reset during ACCESS of a store: the memory write at that edge still occurs; no ack issued; state IDLE next cycle.
- Reset during RESP: ack deasserts next cycle, no further effect.
- Request withdrawn before ack: protocol violation; arbiter completes the access regardless.

Optional Feature:
ARB_STATS_EN: defined -> adds outputs if_grant_cnt and dm_grant_cnt (16 bits each), incremented on each grant in IDLE, saturating at 16'hFFFF, cleared by reset. Undefined -> ports and counters absent, behaviour otherwise identical.

Test Plan:
- Reset: hold reset 2 cycles mid-transfer -> all outputs 0, busy 0, state IDLE next cycle.
- dm store addr=2'h1 data=16'hBEEF, then dm load addr=1 -> mem_write_enable high one cycle only; load dm_ack at N+2 with dm_rdata=16'hBEEF.
- if load addr=3 (mem preloaded 16'h1234) -> if_ack exactly 2 cycles after req sampled, if_rdata=16'h1234, dm_ack stays 0.
- Simultaneous if_req and dm_req, counter 0 -> dm served first, if served in next IDLE; acks never overlap.
- if_req held high, dm_req held high continuously, MAX_BURST=4 -> grant order dm,dm,dm,dm,if,dm,dm,dm,dm,if.
- Store in ACCESS with reset asserted -> memory holds new word, no dm_ack; with ARB_STATS_EN, dm_grant_cnt reads 0 after reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port, synchronous-write memory; one access per three cycles.
// Define ARB_STATS_EN to add saturating per-port grant counters (if_grant_cnt, dm_grant_cnt).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
`ifdef ARB_STATS_EN
    output logic [15:0]           if_grant_cnt,
    output logic [15:0]           dm_grant_cnt,
`endif
    output logic                  busy
);

    // state  | meaning
    // IDLE   | sample requests, pick a winner, latch its command
    // ACCESS | memory cycle; store strobes write enable, reads are captured
    // RESP   | one-cycle ack to the owner; requests ignored
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state;
    owner_t     owner;
    logic [3:0] burst_cnt;
    logic       dm_win;
    logic       if_win;

    // Data port wins unless fetch has already waited through a full burst.
    assign dm_win = dm_req && (!if_req || (burst_cnt < BURST_MAX));
    assign if_win = if_req && !dm_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            owner            <= OWN_NONE;
            burst_cnt        <= '0;
            if_ack           <= 1'b0;
            dm_ack           <= 1'b0;
            if_rdata         <= '0;
            dm_rdata         <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            busy             <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_write_enable <= 1'b0;
                    if (dm_win) begin
                        mem_address      <= dm_addr;
                        mem_write_data   <= dm_wdata;
                        mem_write_enable <= dm_we;
                        owner            <= OWN_DM;
                        state            <= S_ACCESS;
                        busy             <= 1'b1;
                        if (!if_req)
                            burst_cnt <= '0;
                        else if (burst_cnt != BURST_MAX)
                            burst_cnt <= burst_cnt + 4'd1;
                    end else if (if_win) begin
                        mem_address <= if_addr;
                        owner       <= OWN_IF;
                        state       <= S_ACCESS;
                        busy        <= 1'b1;
                        burst_cnt   <= '0;
                    end
                end
                S_ACCESS: begin
                    mem_write_enable <= 1'b0;
                    state            <= S_RESP;
                    if (owner == OWN_IF) begin
                        if_rdata <= mem_read_data;
                        if_ack   <= 1'b1;
                    end else if (owner == OWN_DM) begin
                        // write enable is still high here only for a store
                        if (!mem_write_enable)
                            dm_rdata <= mem_read_data;
                        dm_ack <= 1'b1;
                    end
                end
                S_RESP: begin
                    mem_write_enable <= 1'b0;
                    state            <= S_IDLE;
                    owner            <= OWN_NONE;
                    busy             <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if_grant_cnt <= '0;
            dm_grant_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (dm_win && (dm_grant_cnt != 16'hFFFF))
                dm_grant_cnt <= dm_grant_cnt + 16'd1;
            else if (if_win && (if_grant_cnt != 16'hFFFF))
                if_grant_cnt <= if_grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model (grant slots, ack times, memory image).
module tb_mem_arbiter;
    localparam int MAX_BURST = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic [7:0]  mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_enable;
    logic [15:0] mem_read_data;
    logic        busy;
`ifdef ARB_STATS_EN
    logic [15:0] if_grant_cnt;
    logic [15:0] dm_grant_cnt;
`endif

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
`ifdef ARB_STATS_EN
        .if_grant_cnt(if_grant_cnt), .dm_grant_cnt(dm_grant_cnt),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 3) return 16'h1234;
        return 16'(i * 257) ^ 16'h5a5a;
    endfunction

    // Memory block: combinational read, write on rising edge.
    logic [15:0] mem [0:255];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_address];

    // Reference model state
    logic [15:0] ref_mem [0:255];
    bit          e_if_ack [8];
    bit          e_dm_ack [8];
    bit          e_dm_load[8];
    bit          e_we     [8];
    bit          e_busy   [8];
    logic [15:0] e_if_data[8];
    logic [15:0] e_dm_data[8];
    logic [15:0] h_if_rdata, h_dm_rdata, h_wd;
    logic [7:0]  h_addr;
    int          burst, next_free, cyc;
    int          st_if, st_dm;
    bit          store_granted;

    // Requesters
    typedef struct {bit we; logic [7:0] addr; logic [15:0] data;} op_t;
    op_t         dm_q[$];
    logic [7:0]  if_q[$];
    bit          ack_log[$];
    bit          if_pend, dm_pend, d_we, mode_rand, mode_hold;
    logic [7:0]  if_a, d_a;
    logic [15:0] d_wd;
    op_t         op;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_slot(input int s);
        e_if_ack[s] = 0; e_dm_ack[s] = 0; e_dm_load[s] = 0;
        e_we[s] = 0; e_busy[s] = 0; e_if_data[s] = '0; e_dm_data[s] = '0;
    endtask

    // One clock period: check outputs, advance requesters, model the coming edge.
    task automatic step(input bit rst);
        int s, s1, s2;
        bit dm_win;
        @(negedge clk);
        s = cyc % 8;
        if (e_if_ack[s]) h_if_rdata = e_if_data[s];
        if (e_dm_ack[s] && e_dm_load[s]) h_dm_rdata = e_dm_data[s];
        check("if_ack", if_ack, e_if_ack[s]);
        check("dm_ack", dm_ack, e_dm_ack[s]);
        check("mem_we", mem_write_enable, e_we[s]);
        check("busy", busy, e_busy[s]);
        check("if_rdata", if_rdata, h_if_rdata);
        check("dm_rdata", dm_rdata, h_dm_rdata);
        check("mem_address", mem_address, h_addr);
        check("mem_wdata", mem_write_data, h_wd);
`ifdef ARB_STATS_EN
        check("if_grant_cnt", if_grant_cnt, st_if);
        check("dm_grant_cnt", dm_grant_cnt, st_dm);
`endif
        if (if_ack) ack_log.push_back(1'b0);
        if (dm_ack) ack_log.push_back(1'b1);
        if (e_if_ack[s]) if_pend = 0;
        if (e_dm_ack[s]) dm_pend = 0;
        clear_slot(s);

        if (rst) begin
            if_pend = 0;
            dm_pend = 0;
        end else begin
            if (!if_pend) begin
                if (if_q.size() > 0) begin
                    if_pend = 1; if_a = if_q.pop_front();
                end else if (mode_hold || (mode_rand && $urandom_range(0, 2) == 0)) begin
                    if_pend = 1; if_a = 8'($urandom_range(0, 15));
                end
            end
            if (!dm_pend) begin
                if (dm_q.size() > 0) begin
                    op = dm_q.pop_front();
                    dm_pend = 1; d_we = op.we; d_a = op.addr; d_wd = op.data;
                end else if (mode_hold || (mode_rand && $urandom_range(0, 2) == 0)) begin
                    dm_pend = 1; d_we = 1'($urandom_range(0, 1));
                    d_a = 8'($urandom_range(0, 15)); d_wd = 16'($urandom);
                end
            end
        end
        reset = rst;
        if_req = if_pend; if_addr = if_a;
        dm_req = dm_pend; dm_we = d_we; dm_addr = d_a; dm_wdata = d_wd;

        if (rst) begin
            for (int i = 0; i < 8; i++) clear_slot(i);
            h_if_rdata = '0; h_dm_rdata = '0; h_addr = '0; h_wd = '0;
            burst = 0; st_if = 0; st_dm = 0;
            next_free = cyc + 1;
        end else if (cyc >= next_free && (if_pend || dm_pend)) begin
            dm_win = dm_pend && (!if_pend || burst < MAX_BURST);
            s1 = (cyc + 1) % 8;
            s2 = (cyc + 2) % 8;
            e_busy[s1] = 1;
            e_busy[s2] = 1;
            if (dm_win) begin
                burst = if_pend ? ((burst < MAX_BURST) ? burst + 1 : burst) : 0;
                h_addr = d_a;
                h_wd = d_wd;
                e_dm_ack[s2] = 1;
                if (d_we) begin
                    e_we[s1] = 1;
                    ref_mem[d_a] = d_wd;
                    store_granted = 1;
                end else begin
                    e_dm_load[s2] = 1;
                    e_dm_data[s2] = ref_mem[d_a];
                end
                if (st_dm < 16'hFFFF) st_dm++;
            end else begin
                burst = 0;
                h_addr = if_a;
                e_if_ack[s2] = 1;
                e_if_data[s2] = ref_mem[if_a];
                if (st_if < 16'hFFFF) st_if++;
            end
            next_free = cyc + 3;
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((if_q.size() > 0 || dm_q.size() > 0 || if_pend || dm_pend || cyc < next_free) && n < 60) begin
            step(1'b0);
            n++;
        end
        check("drain_timeout", n >= 60, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 8; i++) clear_slot(i);
        reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_pend = 0; dm_pend = 0; d_we = 0; if_a = '0; d_a = '0; d_wd = '0;
        mode_rand = 0; mode_hold = 0; store_granted = 0;
        h_if_rdata = '0; h_dm_rdata = '0; h_addr = '0; h_wd = '0;
        burst = 0; next_free = 0; cyc = 0; st_if = 0; st_dm = 0;

        step(1'b1);
        step(1'b1);
        step(1'b0);

        // Store then load at address 1
        dm_q.push_back('{we: 1'b1, addr: 8'h01, data: 16'hBEEF});
        dm_q.push_back('{we: 1'b0, addr: 8'h01, data: 16'h0000});
        drain();
        check("dm_load_beef", dm_rdata, 16'hBEEF);

        // Fetch of preloaded word
        if_q.push_back(8'h03);
        drain();
        check("if_fetch_1234", if_rdata, 16'h1234);

        // Simultaneous requests: data first, fetch in the following slot
        ack_log.delete();
        if_q.push_back(8'h03);
        dm_q.push_back('{we: 1'b0, addr: 8'h01, data: 16'h0000});
        drain();
        check("simul_count", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("simul_first_dm", ack_log[0], 1);
            check("simul_second_if", ack_log[1], 0);
        end

        // Both ports requesting continuously from a cleared burst counter
        step(1'b1);
        ack_log.delete();
        mode_hold = 1;
        for (int i = 0; i < 40; i++) step(1'b0);
        mode_hold = 0;
        drain();
        check("burst_count", ack_log.size() >= 10, 1);
        if (ack_log.size() >= 10)
            for (int i = 0; i < 10; i++)
                check("burst_order", ack_log[i], (i % (MAX_BURST + 1) == MAX_BURST) ? 0 : 1);

        // Random traffic with occasional resets
        mode_rand = 1;
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 99) == 0);
        mode_rand = 0;
        drain();

        // Two-cycle reset in the middle of a load
        dm_q.push_back('{we: 1'b0, addr: 8'h05, data: 16'h0000});
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);

        // Reset while a store is in its memory cycle: write lands, no ack
        drain();
        store_granted = 0;
        dm_q.push_back('{we: 1'b1, addr: 8'h09, data: 16'hCAFE});
        step(1'b0);
        check("rst_store_granted", store_granted, 1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("rst_store_mem", mem[9], 16'hCAFE);

        // Memory still consistent for a later load of that word
        dm_q.push_back('{we: 1'b0, addr: 8'h09, data: 16'h0000});
        drain();
        check("post_rst_load", dm_rdata, 16'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
